// File: rtl/branch_dir_predictor.sv
// Gshare direction predictor: 256 x 2-bit pattern table indexed by pc XOR global history,
// with single-cycle mispredict recovery and resolved/mispredicted branch counters.
module branch_dir_predictor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        br_inst_detect,
  input  logic [19:0] btb_tag_val,
  input  logic [31:0] btb_pred_pc_val,
  input  logic        stall,
  input  logic        ex_br_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic [7:0]  ex_old_pattern,
  input  logic [31:0] ex_target,
  output logic        pred_taken,
  output logic [31:0] next_pc,
  output logic [7:0]  new_pattern,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [15:0] br_count,
  output logic [15:0] mp_count
);

  logic [7:0]  ghr_q, ghr_d;
  logic [1:0]  pht_q [256];
  logic [1:0]  pht_d [256];
  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [15:0] br_count_q, br_count_d;
  logic [15:0] mp_count_q, mp_count_d;

  logic [7:0]  rd_idx;
  logic [7:0]  upd_idx;
  logic [1:0]  upd_ctr;
  logic        hit;
  logic        mp_case;

  assign rd_idx  = pc[9:2] ^ ghr_q;
  assign upd_idx = ex_pc[9:2] ^ ex_old_pattern;
  assign hit     = br_inst_detect && (btb_tag_val == pc[31:12]) && (btb_pred_pc_val != 32'd0);
  assign mp_case = ex_br_valid && (ex_taken != ex_pred_taken);

  // The fetch read sees the pre-update table; an EX write lands on the next edge.
  assign pred_taken  = hit && pht_q[rd_idx][1];
  assign next_pc     = pred_taken ? btb_pred_pc_val : (pc + 32'd4);
  assign new_pattern = ghr_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign br_count    = br_count_q;
  assign mp_count    = mp_count_q;

  always_comb begin
    pht_d   = pht_q;
    upd_ctr = pht_q[upd_idx];
    if (ex_br_valid) begin
      if (ex_taken) begin
        pht_d[upd_idx] = (upd_ctr == 2'd3) ? 2'd3 : upd_ctr + 2'd1;
      end else begin
        pht_d[upd_idx] = (upd_ctr == 2'd0) ? 2'd0 : upd_ctr - 2'd1;
      end
    end
  end

  // Recovery rebuilds history from the branch's own snapshot, overriding any fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (mp_case) begin
      ghr_d = {ex_old_pattern[6:0], ex_taken};
    end else if (br_inst_detect && !stall) begin
      ghr_d = {ghr_q[6:0], pred_taken};
    end
  end

  always_comb begin
    mispredict_d  = mp_case;
    redirect_pc_d = redirect_pc_q;
    if (mp_case) begin
      redirect_pc_d = ex_taken ? ex_target : (ex_pc + 32'd4);
    end
    br_count_d = br_count_q;
    if (ex_br_valid && (br_count_q != 16'hFFFF)) begin
      br_count_d = br_count_q + 16'd1;
    end
    mp_count_d = mp_count_q;
    if (mp_case && (mp_count_q != 16'hFFFF)) begin
      mp_count_d = mp_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        pht_q[i] <= 2'b01;
      end
      ghr_q         <= 8'd0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= 32'd0;
      br_count_q    <= 16'd0;
      mp_count_q    <= 16'd0;
    end else begin
      pht_q         <= pht_d;
      ghr_q         <= ghr_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      br_count_q    <= br_count_d;
      mp_count_q    <= mp_count_d;
    end
  end

endmodule

// File: tb/tb_branch_dir_predictor.sv
// Self-checking bench for branch_dir_predictor: directed scenarios plus random traffic
// compared against an arithmetic reference model of the predictor rules.
module tb_branch_dir_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc = 32'd0;
  logic        br_inst_detect = 1'b0;
  logic [19:0] btb_tag_val = 20'd0;
  logic [31:0] btb_pred_pc_val = 32'd0;
  logic        stall = 1'b0;
  logic        ex_br_valid = 1'b0;
  logic [31:0] ex_pc = 32'd0;
  logic        ex_taken = 1'b0;
  logic        ex_pred_taken = 1'b0;
  logic [7:0]  ex_old_pattern = 8'd0;
  logic [31:0] ex_target = 32'd0;
  logic        pred_taken;
  logic [31:0] next_pc;
  logic [7:0]  new_pattern;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] br_count;
  logic [15:0] mp_count;

  branch_dir_predictor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .br_inst_detect  (br_inst_detect),
    .btb_tag_val     (btb_tag_val),
    .btb_pred_pc_val (btb_pred_pc_val),
    .stall           (stall),
    .ex_br_valid     (ex_br_valid),
    .ex_pc           (ex_pc),
    .ex_taken        (ex_taken),
    .ex_pred_taken   (ex_pred_taken),
    .ex_old_pattern  (ex_old_pattern),
    .ex_target       (ex_target),
    .pred_taken      (pred_taken),
    .next_pc         (next_pc),
    .new_pattern     (new_pattern),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .br_count        (br_count),
    .mp_count        (mp_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: plain integers, counters clamp with min/max arithmetic.
  int          m_pht [256];
  int          m_ghr;
  int          m_mp;
  logic [31:0] m_redir;
  int          m_br;
  int          m_mpc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr   = 0;
    m_mp    = 0;
    m_redir = 32'd0;
    m_br    = 0;
    m_mpc   = 0;
  endfunction

  function automatic bit model_pred();
    bit hit;
    int idx;
    hit = br_inst_detect && (btb_tag_val == pc[31:12]) && (btb_pred_pc_val != 0);
    idx = ((pc >> 2) % 256) ^ m_ghr;
    return hit && (m_pht[idx] >= 2);
  endfunction

  // One clock: compare everything at the negedge, then advance the model at the posedge.
  task automatic step(input bit verbose);
    bit          exp_pt;
    logic [31:0] exp_npc;
    bit          mp_now;
    int          uidx;
    @(negedge clk);
    exp_pt  = model_pred();
    exp_npc = exp_pt ? btb_pred_pc_val : pc + 32'd4;
    check_eq("pred_taken",  {31'd0, pred_taken}, {31'd0, exp_pt});
    check_eq("next_pc",     next_pc, exp_npc);
    check_eq("new_pattern", {24'd0, new_pattern}, m_ghr);
    check_eq("mispredict",  {31'd0, mispredict}, m_mp);
    check_eq("redirect_pc", redirect_pc, m_redir);
    check_eq("br_count",    {16'd0, br_count}, m_br);
    check_eq("mp_count",    {16'd0, mp_count}, m_mpc);
    if (verbose)
      $display("cyc %0d pc=%08h br=%b st=%b ex_v=%b ex_t=%b ex_p=%b -> pt=%b npc=%08h ghr=%02h mp=%b rpc=%08h brc=%0d mpc=%0d",
               cyc, pc, br_inst_detect, stall, ex_br_valid, ex_taken, ex_pred_taken,
               pred_taken, next_pc, new_pattern, mispredict, redirect_pc, br_count, mp_count);
    @(posedge clk);
    mp_now = ex_br_valid && (ex_taken != ex_pred_taken);
    if (ex_br_valid) begin
      uidx = ((ex_pc >> 2) % 256) ^ ex_old_pattern;
      m_pht[uidx] = ex_taken ? ((m_pht[uidx] + 1 > 3) ? 3 : m_pht[uidx] + 1)
                             : ((m_pht[uidx] - 1 < 0) ? 0 : m_pht[uidx] - 1);
      m_br = (m_br + 1 > 65535) ? 65535 : m_br + 1;
    end
    if (mp_now) begin
      m_ghr   = (ex_old_pattern * 2 + ex_taken) % 256;
      m_redir = ex_taken ? ex_target : ex_pc + 32'd4;
      m_mpc   = (m_mpc + 1 > 65535) ? 65535 : m_mpc + 1;
    end else if (br_inst_detect && !stall) begin
      m_ghr = (m_ghr * 2 + exp_pt) % 256;
    end
    m_mp = mp_now;
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    br_inst_detect = 1'b0;
    stall          = 1'b0;
    ex_br_valid    = 1'b0;
    ex_taken       = 1'b0;
    ex_pred_taken  = 1'b0;
    ex_old_pattern = 8'd0;
  endtask

  // Assert reset between edges so the asynchronous clear is observed without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mispredict",  {31'd0, mispredict}, 32'd0);
    check_eq("rst_redirect_pc", redirect_pc, 32'd0);
    check_eq("rst_br_count",    {16'd0, br_count}, 32'd0);
    check_eq("rst_mp_count",    {16'd0, mp_count}, 32'd0);
    check_eq("rst_ghr",         {24'd0, new_pattern}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    #1;
    do_reset();

    // Cold prediction: counters start weakly not-taken.
    pc = 32'h1000; br_inst_detect = 1'b1; btb_tag_val = 20'h00001; btb_pred_pc_val = 32'h2000;
    #1;
    check_eq("cold_pred", {31'd0, pred_taken}, 32'd0);
    check_eq("cold_npc", next_pc, 32'h1004);
    step(1);
    check_eq("cold_ghr", {24'd0, new_pattern}, 32'h00);

    // Two taken resolutions of entry 0, both mispredicted.
    br_inst_detect = 1'b0;
    ex_br_valid = 1'b1; ex_pc = 32'h1000; ex_old_pattern = 8'h00;
    ex_pred_taken = 1'b0; ex_taken = 1'b1; ex_target = 32'h3000;
    step(1);
    check_eq("mp_pulse1", {31'd0, mispredict}, 32'd1);
    check_eq("redirect1", redirect_pc, 32'h3000);
    step(1);
    ex_br_valid = 1'b0;
    check_eq("mp_pulse2", {31'd0, mispredict}, 32'd1);
    check_eq("mp_count2", {16'd0, mp_count}, 32'd2);
    step(1);
    check_eq("mp_drop", {31'd0, mispredict}, 32'd0);
    check_eq("redirect_hold", redirect_pc, 32'h3000);

    // GHR is now 0x01, so pc 0x1004 maps back onto entry 0 (counter 3).
    pc = 32'h1004; br_inst_detect = 1'b1;
    #1;
    check_eq("strong_pred", {31'd0, pred_taken}, 32'd1);
    check_eq("strong_npc", next_pc, 32'h2000);
    step(1);
    check_eq("strong_ghr", {24'd0, new_pattern}, 32'h03);
    br_inst_detect = 1'b0;
    ex_br_valid = 1'b1; ex_pred_taken = 1'b1; ex_taken = 1'b1;
    repeat (4) step(1);
    ex_br_valid = 1'b0;
    pc = 32'h100C; br_inst_detect = 1'b1;
    step(1);

    // Recovery wins over a same-cycle fetch shift.
    pc = 32'h1000; br_inst_detect = 1'b1;
    ex_br_valid = 1'b1; ex_pc = 32'h1000; ex_old_pattern = 8'h5A; ex_taken = 1'b0; ex_pred_taken = 1'b1;
    step(1);
    check_eq("recover_ghr", {24'd0, new_pattern}, 32'hB4);
    check_eq("recover_rpc", redirect_pc, 32'h1004);

    // Stall freezes history but not the update path.
    begin
      int br_before;
      br_before = m_br;
      stall = 1'b1; br_inst_detect = 1'b1;
      ex_br_valid = 1'b1; ex_pc = 32'h2000; ex_old_pattern = 8'h00; ex_taken = 1'b1; ex_pred_taken = 1'b1;
      step(1);
      check_eq("stall_ghr", {24'd0, new_pattern}, 32'hB4);
      check_eq("stall_brc", {16'd0, br_count}, br_before + 1);
    end
    idle_inputs();
    step(1);

    // Reset in the middle of a pending mispredict discards it.
    ex_br_valid = 1'b1; ex_pc = 32'h4000; ex_taken = 1'b1; ex_pred_taken = 1'b0; ex_target = 32'h5000;
    do_reset();
    step(1);
    check_eq("post_rst_mp", {31'd0, mispredict}, 32'd0);

    // Random traffic: mostly BTB hits on a few PCs so history and table aliasing interact.
    for (int n = 0; n < 1500; n++) begin
      pc              = {$urandom_range(0, 3), 10'd0, 8'($urandom), 2'b00} + 32'h1000;
      br_inst_detect  = ($urandom_range(0, 3) != 0);
      btb_tag_val     = ($urandom_range(0, 4) != 0) ? pc[31:12] : 20'($urandom);
      btb_pred_pc_val = ($urandom_range(0, 9) != 0) ? $urandom : 32'd0;
      stall           = ($urandom_range(0, 4) == 0);
      ex_br_valid     = ($urandom_range(0, 1) != 0);
      ex_pc           = {20'd1, 2'($urandom), 8'($urandom), 2'b00};
      ex_taken        = 1'($urandom);
      ex_pred_taken   = 1'($urandom);
      ex_old_pattern  = 8'($urandom);
      ex_target       = $urandom;
      step(1);
    end

    // Counter saturation: every cycle resolves a mispredicted branch.
    idle_inputs();
    ex_br_valid = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b0; ex_pc = 32'h1000; ex_target = 32'h6000;
    for (int n = 0; n < 65540; n++) step(0);
    ex_br_valid = 1'b0;
    step(1);
    check_eq("sat_br_count", {16'd0, br_count}, 32'h0000FFFF);
    check_eq("sat_mp_count", {16'd0, mp_count}, 32'h0000FFFF);
    ex_br_valid = 1'b1; ex_taken = 1'b0; ex_pred_taken = 1'b0;
    step(1);
    ex_br_valid = 1'b0;
    check_eq("sat_br_hold", {16'd0, br_count}, 32'h0000FFFF);

    // PC wrap on a non-predicted fetch.
    pc = 32'hFFFF_FFFC; br_inst_detect = 1'b0;
    #1;
    check_eq("wrap_npc", next_pc, 32'h0000_0000);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
